// File: rtl/car_motion_ctrl.sv
// Turns filtered Bluetooth command codes into H-bridge pins and a soft-start PWM enable,
// with a coast dead-time before any direction reversal and a latched route select.
module car_motion_ctrl #(
  parameter int PWM_PERIOD   = 1000,
  parameter int DUTY_MAX     = 800,
  parameter int RAMP_STEP    = 8,
  parameter int DEADTIME_CYC = 500000,
  parameter int STABLE_CYC   = 1000
) (
  input  logic       inclk,
  input  logic       rst_n,
  input  logic [2:0] c_s,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] route_sel,
  output logic       busy
);

  // CW must hold PWM_PERIOD-1 and DUTY_MAX (DUTY_MAX <= PWM_PERIOD).
  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD + 1) : 1;
  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DUTY_TOP  = CW'(DUTY_MAX);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYC - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);

  // Pin patterns are {in1, in2, in3, in4}; left side is in1/in2, right side in3/in4.
  localparam logic [3:0] P_STOP  = 4'b0000;
  localparam logic [3:0] P_FWD   = 4'b1010;
  localparam logic [3:0] P_REV   = 4'b0101;
  localparam logic [3:0] P_LEFT  = 4'b0110;
  localparam logic [3:0] P_RIGHT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_e;

  logic [2:0]    meta_q, sync_q;
  logic [2:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [2:0]    acc_q, acc_d;
  logic [3:0]    tgt_q, tgt_d;
  logic [1:0]    route_q, route_d;

  state_e        state_q, state_d;
  logic [3:0]    dir_q, dir_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;

  logic [3:0]    pins_q, pins_d;
  logic          pwm_q, pwm_d;
  logic          busy_q, busy_d;

  logic          pwm_wrap;
  logic [31:0]   duty_sum;
  logic [CW-1:0] duty_ramp;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      acc_q     <= '0;
      tgt_q     <= P_STOP;
      route_q   <= '0;
      state_q   <= IDLE;
      dir_q     <= P_STOP;
      duty_q    <= '0;
      dead_q    <= '0;
      pwm_cnt_q <= '0;
      pins_q    <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      meta_q    <= c_s;
      sync_q    <= meta_q;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      acc_q     <= acc_d;
      tgt_q     <= tgt_d;
      route_q   <= route_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      dead_q    <= dead_d;
      pwm_cnt_q <= pwm_cnt_d;
      pins_q    <= pins_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
    end
  end

  // Acceptance uses the next count so a steady code lands exactly STABLE_CYC cycles after sync.
  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    acc_d   = acc_q;
    tgt_d   = tgt_q;
    route_d = route_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      stab_d = '0;
    end else if (stab_q != STAB_LAST) begin
      stab_d = stab_q + 1'b1;
    end
    if ((stab_d == STAB_LAST) && (cand_d != acc_q)) begin
      acc_d = cand_d;
      case (cand_d)
        3'b001:  route_d = 2'b01;
        3'b010:  route_d = 2'b10;
        3'b011:  tgt_d   = P_FWD;
        3'b100:  tgt_d   = P_REV;
        3'b101:  tgt_d   = P_LEFT;
        3'b110:  tgt_d   = P_RIGHT;
        default: tgt_d   = P_STOP;
      endcase
    end
  end

  assign pwm_wrap  = (pwm_cnt_q == PWM_LAST);
  assign pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;

  // Sum in 32 bits so the ramp saturates instead of wrapping.
  assign duty_sum  = 32'(duty_q) + 32'(RAMP_STEP);
  assign duty_ramp = (duty_sum >= 32'(DUTY_MAX)) ? DUTY_TOP : CW'(duty_sum);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        dir_d  = P_STOP;
        duty_d = '0;
        if (tgt_q != P_STOP) begin
          state_d = RUN;
          dir_d   = tgt_q;
        end
      end
      RUN: begin
        if (tgt_q != dir_q) begin
          state_d = DEAD;
          dir_d   = P_STOP;
          duty_d  = '0;
          dead_d  = '0;
        end else if (pwm_wrap) begin
          duty_d = duty_ramp;
        end
      end
      DEAD: begin
        duty_d = '0;
        if (dead_q == DEAD_LAST) begin
          if (tgt_q == P_STOP) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
            dir_d   = tgt_q;
          end
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = P_STOP;
        duty_d  = '0;
      end
    endcase
  end

  always_comb begin
    pins_d = dir_q;
    pwm_d  = (pwm_cnt_q < duty_q);
    busy_d = (state_q == DEAD);
  end

  assign {in1, in2, in3, in4} = pins_q;
  assign pwm_l     = pwm_q;
  assign pwm_r     = pwm_q;
  assign route_sel = route_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl with short periods so whole ramps and dead-times fit.
module tb_car_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] c_s;
  logic       in1, in2, in3, in4, pwm_l, pwm_r, busy;
  logic [1:0] route_sel;
  logic [3:0] pins;
  int         checks = 0;
  int         errors = 0;
  int         cyc;

  car_motion_ctrl #(
    .PWM_PERIOD(10), .DUTY_MAX(8), .RAMP_STEP(2), .DEADTIME_CYC(20), .STABLE_CYC(4)
  ) dut (
    .inclk(clk), .rst_n(rst_n), .c_s(c_s),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .route_sel(route_sel), .busy(busy)
  );

  always #5 clk = ~clk;
  assign pins = {in1, in2, in3, in4};

  // Edges since reset release; equals the DUT's PWM phase counter modulo 10.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic align0();
    while (cyc % 10 != 0) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_s   = 3'b011;
    repeat (3) tick();
    checks++;
    if ({pins, pwm_l, pwm_r, busy, route_sel} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {pins, pwm_l, pwm_r, busy, route_sel}, 9'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int exp_w[6] = '{0, 2, 4, 6, 8, 8};
    int hi = 0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      hi += int'(pwm_l);
      checks++;
      if (pwm_l !== pwm_r) begin
        errors++;
        $display("FAIL ramp_pwm_equal e=%0d: got l=%b r=%b expected equal", e, pwm_l, pwm_r);
      end
      if (e == 7) begin
        checks++;
        if (pins !== 4'b0000) begin
          errors++;
          $display("FAIL ramp_pins_before e=%0d: got %b expected 0000", e, pins);
        end
      end
      if (e == 8) begin
        checks++;
        if (pins !== 4'b1010 || busy !== 1'b0) begin
          errors++;
          $display("FAIL ramp_pins_fwd e=%0d: got pins=%b busy=%b expected 1010 0", e, pins, busy);
        end
      end
      if (e % 10 == 0) begin
        checks++;
        if (hi != exp_w[e/10-1]) begin
          errors++;
          $display("FAIL ramp_window e=%0d: got %0d high expected %0d", e, hi, exp_w[e/10-1]);
        end
        hi = 0;
      end
    end
  endtask

  task automatic test_glitch();
    int hi = 0;
    c_s = 3'b100;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 3) c_s = 3'b011;
      hi += int'(pwm_l);
      checks++;
      if (pins !== 4'b1010 || busy !== 1'b0) begin
        errors++;
        $display("FAIL glitch_pins e=%0d: got pins=%b busy=%b expected 1010 0", e, pins, busy);
      end
      if (e % 10 == 0) begin
        checks++;
        if (hi != 8) begin
          errors++;
          $display("FAIL glitch_duty e=%0d: got %0d high expected 8", e, hi);
        end
        hi = 0;
      end
    end
  endtask

  task automatic test_reversal();
    int hi = 0;
    logic [4:0] exp_v;
    align0();
    c_s = 3'b100;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e >= 8 && e <= 27) exp_v = {1'b1, 4'b0000};
      else if (e <= 7)       exp_v = {1'b0, 4'b1010};
      else                   exp_v = {1'b0, 4'b0101};
      checks++;
      if ({busy, pins} !== exp_v) begin
        errors++;
        $display("FAIL reversal_pins e=%0d: got %b expected %b", e, {busy, pins}, exp_v);
      end
      if (e >= 8 && e <= 30) begin
        checks++;
        if (pwm_l !== 1'b0 || pwm_r !== 1'b0) begin
          errors++;
          $display("FAIL reversal_pwm_off e=%0d: got %b%b expected 00", e, pwm_l, pwm_r);
        end
      end
      if (e >= 31) hi += int'(pwm_l);
      if (e == 40 || e == 50) begin
        checks++;
        if (hi != ((e == 40) ? 2 : 4)) begin
          errors++;
          $display("FAIL reversal_ramp e=%0d: got %0d high expected %0d", e, hi, (e == 40) ? 2 : 4);
        end
        hi = 0;
      end
    end
  endtask

  task automatic test_mid_dead();
    logic [4:0] exp_v;
    c_s = 3'b011;
    repeat (40) tick();
    align0();
    c_s = 3'b100;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 11) c_s = 3'b101;
      if (e >= 8 && e <= 27) exp_v = {1'b1, 4'b0000};
      else if (e <= 7)       exp_v = {1'b0, 4'b1010};
      else                   exp_v = {1'b0, 4'b0110};
      checks++;
      if ({busy, pins} !== exp_v) begin
        errors++;
        $display("FAIL mid_dead e=%0d: got %b expected %b", e, {busy, pins}, exp_v);
      end
    end
  endtask

  task automatic test_route_stop();
    logic [6:0] exp_v;
    c_s = 3'b011;
    repeat (40) tick();
    c_s = 3'b001;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_v = {(e >= 6) ? 2'b01 : 2'b00, 1'b0, 4'b1010};
      checks++;
      if ({route_sel, busy, pins} !== exp_v) begin
        errors++;
        $display("FAIL route_set e=%0d: got %b expected %b", e, {route_sel, busy, pins}, exp_v);
      end
    end
    c_s = 3'b111;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e <= 7)       exp_v = {2'b01, 1'b0, 4'b1010};
      else if (e <= 27) exp_v = {2'b01, 1'b1, 4'b0000};
      else              exp_v = {2'b01, 1'b0, 4'b0000};
      checks++;
      if ({route_sel, busy, pins} !== exp_v) begin
        errors++;
        $display("FAIL stop_seq e=%0d: got %b expected %b", e, {route_sel, busy, pins}, exp_v);
      end
      if (e >= 8) begin
        checks++;
        if (pwm_l !== 1'b0) begin
          errors++;
          $display("FAIL stop_pwm e=%0d: got %b expected 0", e, pwm_l);
        end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int hi = 0;
    align0();
    c_s = 3'b011;
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e >= 11 && e <= 20) hi += int'(pwm_l);
    end
    checks++;
    if (hi != 2 || pins !== 4'b1010 || route_sel !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: got hi=%0d pins=%b route=%b expected 2 1010 01", hi, pins, route_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pins, pwm_l, pwm_r, busy, route_sel} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {pins, pwm_l, pwm_r, busy, route_sel}, 9'b0);
    end
    tick();
    checks++;
    if ({pins, pwm_l, pwm_r, busy, route_sel} !== 9'b0) begin
      errors++;
      $display("FAIL held_reset: got %b expected %b", {pins, pwm_l, pwm_r, busy, route_sel}, 9'b0);
    end
    rst_n = 1'b1;
    hi = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      hi += int'(pwm_l);
      if (e == 7 || e == 8) begin
        checks++;
        if (pins !== ((e == 7) ? 4'b0000 : 4'b1010)) begin
          errors++;
          $display("FAIL rerun_pins e=%0d: got %b expected %b", e, pins, (e == 7) ? 4'b0000 : 4'b1010);
        end
      end
      if (e == 10 || e == 20) begin
        checks++;
        if (hi != ((e == 10) ? 0 : 2) || route_sel !== 2'b00) begin
          errors++;
          $display("FAIL rerun_ramp e=%0d: got hi=%0d route=%b expected %0d 00", e, hi, route_sel, (e == 10) ? 0 : 2);
        end
        hi = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_glitch();
    test_reversal();
    test_mid_dead();
    test_route_stop();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
